// File: rtl/load_inst_fsm_pkg.sv
// Shared constants and state encoding for the boot-time instruction loader.
// LOADINST_LITTLE_ENDIAN_EN (used by the byte assembler) selects LSB-first packing.
package load_inst_fsm_pkg;

    localparam int DEF_UART_BITS        = 8;
    localparam int DEF_INST_ADDRS_BITS  = 10;
    localparam int DEF_INSTRUCTION_BITS = 32;

    localparam int STATE_BITS = 3;

    localparam logic [STATE_BITS-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_BITS-1:0] ST_WAIT_COUNT = 3'd1;
    localparam logic [STATE_BITS-1:0] ST_RECV       = 3'd2;
    localparam logic [STATE_BITS-1:0] ST_WRITE      = 3'd3;
    localparam logic [STATE_BITS-1:0] ST_DONE       = 3'd4;

    function automatic int bytes_per_inst(input int inst_bits, input int uart_bits);
        return inst_bits / uart_bits;
    endfunction

endpackage

// File: rtl/load_inst_fsm_if.sv
// Loader bus: UART byte stream in, instruction-memory write port and completion out.
// The slave side is the loader; the master side is whoever drives start/rx bytes.
interface load_inst_fsm_if
    import load_inst_fsm_pkg::*;
#(
    parameter int UART_BITS        = DEF_UART_BITS,
    parameter int INST_ADDRS_BITS  = DEF_INST_ADDRS_BITS,
    parameter int INSTRUCTION_BITS = DEF_INSTRUCTION_BITS
) ();

    // Handshake: i_rx_done is a one-cycle valid strobe with no ready/backpressure;
    // the loader is always ready, so a byte is consumed in exactly the cycle it is strobed.
    logic                        i_start;
    logic                        i_rx_done;
    logic [UART_BITS-1:0]        i_rx_data;
    logic                        o_write_inst_mem;
    logic [INST_ADDRS_BITS-1:0]  o_inst_mem_addr;
    logic [INSTRUCTION_BITS-1:0] o_inst_mem_data;
    logic                        o_done;
    logic [STATE_BITS-1:0]       dbg_state;

    modport master (
        output i_start, i_rx_done, i_rx_data,
        input  o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data, o_done, dbg_state
    );

    modport slave (
        input  i_start, i_rx_done, i_rx_data,
        output o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data, o_done, dbg_state
    );

endinterface

// File: rtl/load_inst_fsm_inst_byte_assembler.sv
// Shift register plus byte counter that packs UART bytes into one instruction word.
// Default packing is MSB-first; LOADINST_LITTLE_ENDIAN_EN packs LSB-first.
module load_inst_fsm_inst_byte_assembler
    import load_inst_fsm_pkg::*;
#(
    parameter int UART_BITS        = DEF_UART_BITS,
    parameter int INSTRUCTION_BITS = DEF_INSTRUCTION_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic                        shift_i,
    input  logic [UART_BITS-1:0]        byte_i,
    output logic [INSTRUCTION_BITS-1:0] word_o,
    output logic                        full_o
);

    localparam int BYTES_PER_INST = bytes_per_inst(INSTRUCTION_BITS, UART_BITS);
    localparam int CNT_BITS       = $clog2(BYTES_PER_INST + 1);

    logic [INSTRUCTION_BITS-1:0] word_q, word_d;
    logic [CNT_BITS-1:0]         cnt_q, cnt_d;

    // Clear and shift may coincide: the shifted byte then counts as byte 0.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end
        if (shift_i) begin
`ifdef LOADINST_LITTLE_ENDIAN_EN
            word_d = {byte_i, word_q[INSTRUCTION_BITS-1:UART_BITS]};
`else
            word_d = {word_q[INSTRUCTION_BITS-UART_BITS-1:0], byte_i};
`endif
            cnt_d = cnt_d + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    // Asserted when the next accepted byte completes the word.
    assign full_o = (cnt_q == CNT_BITS'(BYTES_PER_INST - 1));

endmodule

// File: rtl/load_inst_fsm.sv
// Boot loader: after i_start takes a count N, then N instructions of bytes, and
// writes them to instruction memory from address 0. Byte order set by LOADINST_LITTLE_ENDIAN_EN.
module load_inst_fsm
    import load_inst_fsm_pkg::*;
#(
    parameter int UART_BITS        = DEF_UART_BITS,
    parameter int INST_ADDRS_BITS  = DEF_INST_ADDRS_BITS,
    parameter int INSTRUCTION_BITS = DEF_INSTRUCTION_BITS
) (
    input  logic           clk,
    input  logic           rst,
    load_inst_fsm_if.slave bus
);

    logic [STATE_BITS-1:0]       state_q, state_d;
    logic [UART_BITS-1:0]        n_q, n_d;
    logic [UART_BITS-1:0]        inst_cnt_q, inst_cnt_d;
    logic [INST_ADDRS_BITS-1:0]  addr_cnt_q, addr_cnt_d;
    logic                        write_q;
    logic                        done_q;
    logic [INST_ADDRS_BITS-1:0]  addr_q;
    logic [INSTRUCTION_BITS-1:0] data_q;

    logic                        asm_clear;
    logic                        asm_shift;
    logic                        asm_full;
    logic [INSTRUCTION_BITS-1:0] asm_word;

    load_inst_fsm_inst_byte_assembler #(
        .UART_BITS        (UART_BITS),
        .INSTRUCTION_BITS (INSTRUCTION_BITS)
    ) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear_i (asm_clear),
        .shift_i (asm_shift),
        .byte_i  (bus.i_rx_data),
        .word_o  (asm_word),
        .full_o  (asm_full)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        inst_cnt_d = inst_cnt_q;
        addr_cnt_d = addr_cnt_q;
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d    = ST_WAIT_COUNT;
                    inst_cnt_d = '0;
                    addr_cnt_d = '0;
                    asm_clear  = 1'b1;
                end
            end
            ST_WAIT_COUNT: begin
                if (bus.i_rx_done) begin
                    n_d     = bus.i_rx_data;
                    state_d = (bus.i_rx_data == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (bus.i_rx_done) begin
                    asm_shift = 1'b1;
                    if (asm_full) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // A byte strobed here starts the next word rather than being dropped.
                asm_clear  = 1'b1;
                asm_shift  = bus.i_rx_done;
                inst_cnt_d = inst_cnt_q + UART_BITS'(1);
                addr_cnt_d = addr_cnt_q + INST_ADDRS_BITS'(1);
                state_d    = ((inst_cnt_q + UART_BITS'(1)) == n_q) ? ST_DONE : ST_RECV;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            inst_cnt_q <= '0;
            addr_cnt_q <= '0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            inst_cnt_q <= inst_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            write_q    <= (state_q == ST_WRITE);
            done_q     <= (state_q == ST_DONE);
            if (state_q == ST_WRITE) begin
                addr_q <= addr_cnt_q;
                data_q <= asm_word;
            end
        end
    end

    assign bus.o_write_inst_mem = write_q;
    assign bus.o_inst_mem_addr  = addr_q;
    assign bus.o_inst_mem_data  = data_q;
    assign bus.o_done           = done_q;
    assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_load_inst_fsm.sv
// Directed-plus-random bench for load_inst_fsm with a word-level reference model.
// Honours LOADINST_LITTLE_ENDIAN_EN when computing expected words.
module tb_load_inst_fsm;
    import load_inst_fsm_pkg::*;

    localparam int UB  = DEF_UART_BITS;
    localparam int AB  = DEF_INST_ADDRS_BITS;
    localparam int IB  = DEF_INSTRUCTION_BITS;
    localparam int BPI = IB / UB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_inst_fsm_if bus ();

    load_inst_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks;
    int errors;
    int cyc;
    int done_cnt;
    int done_cyc;
    int exp_done_cyc;
    int last_edge;
    logic [AB+IB-1:0] exp_q[$];
    logic [AB+IB-1:0] got_q[$];
    int               exp_cyc_q[$];
    int               got_cyc_q[$];
    logic [UB-1:0]    stim_b[$];
    logic [IB-1:0]    nom_w[3];
    logic [IB-1:0]    beef_w;
    logic [IB-1:0]    tmp_w;
    int               n_rand;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_write_inst_mem === 1'b1) begin
            got_q.push_back({bus.o_inst_mem_addr, bus.o_inst_mem_data});
            got_cyc_q.push_back(cyc);
        end
        if (bus.o_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [UB-1:0] b, input int gap);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = b;
        tick();
        last_edge     = cyc;
        bus.i_rx_done = 1'b0;
        bus.i_start   = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_cyc_q.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    // Reference packing: byte k of an instruction carries weight 2^(UB*(BPI-1-k)),
    // or 2^(UB*k) when packing little-endian.
    function automatic logic [IB-1:0] pack_word(input int base);
        logic [IB-1:0] w;
        w = '0;
        for (int k = 0; k < BPI; k++) begin
`ifdef LOADINST_LITTLE_ENDIAN_EN
            w = w + (IB'(stim_b[base+k]) << (UB * k));
`else
            w = (w << UB) + IB'(stim_b[base+k]);
`endif
        end
        return w;
    endfunction

    task automatic fill_random(input int n);
        stim_b.delete();
        for (int i = 0; i < n * BPI; i++) stim_b.push_back(UB'($urandom));
    endtask

    task automatic run_load(input string tag, input logic [UB-1:0] n, input int gmin,
                            input int gmax, input int stray_idx);
        int waited;
        exp_q.delete();
        exp_cyc_q.delete();
        clear_obs();
        for (int i = 0; i < int'(n); i++) exp_q.push_back({AB'(i), pack_word(i * BPI)});
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        send_byte(n, int'($urandom_range(gmax, gmin)));
        exp_done_cyc = last_edge + 1;
        for (int i = 0; i < stim_b.size(); i++) begin
            if (i == stray_idx) bus.i_start = 1'b1;
            send_byte(stim_b[i], int'($urandom_range(gmax, gmin)));
            if ((i % BPI) == BPI - 1) begin
                exp_cyc_q.push_back(last_edge + 1);
                exp_done_cyc = last_edge + 2;
            end
        end
        waited = 0;
        while (done_cnt == 0 && waited < 64) begin
            tick();
            waited = waited + 1;
        end
        repeat (4) tick();
        chk({tag, " writes"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk({tag, " addr+data"}, 64'(got_q[i]), 64'(exp_q[i]));
                chk({tag, " write cycle"}, 64'(got_cyc_q[i]), 64'(exp_cyc_q[i]));
            end
        end
        chk({tag, " done pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, " done cycle"}, 64'(done_cyc), 64'(exp_done_cyc));
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef LOADINST_LITTLE_ENDIAN_EN
        nom_w[0] = 32'h03020100;
        nom_w[1] = 32'h07060504;
        nom_w[2] = 32'h0B0A0908;
        beef_w   = 32'hEFBEADDE;
`else
        nom_w[0] = 32'h00010203;
        nom_w[1] = 32'h04050607;
        nom_w[2] = 32'h08090A0B;
        beef_w   = 32'hDEADBEEF;
`endif

        // Reset
        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = '0;
        repeat (2) tick();
        chk("reset write", 64'(bus.o_write_inst_mem), 64'd0);
        chk("reset done", 64'(bus.o_done), 64'd0);
        chk("reset addr", 64'(bus.o_inst_mem_addr), 64'd0);
        chk("reset data", 64'(bus.o_inst_mem_data), 64'd0);
        rst = 1'b0;
        tick();

        // Byte while idle is ignored
        clear_obs();
        send_byte(8'h55, 5);
        chk("idle writes", 64'(got_q.size()), 64'd0);
        chk("idle done", 64'(done_cnt), 64'd0);

        // Nominal: N=3, bytes 0x00..0x0B spaced 4 cycles apart
        stim_b.delete();
        for (int i = 0; i < 12; i++) stim_b.push_back(UB'(i));
        run_load("nominal", 8'd3, 3, 3, -1);
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) begin
                tmp_w = got_q[i][IB-1:0];
                chk("nominal word", 64'(tmp_w), 64'(nom_w[i]));
            end
        end
        chk("addr hold", 64'(bus.o_inst_mem_addr), 64'd2);

        // N=0: done only
        stim_b.delete();
        run_load("count_zero", 8'd0, 1, 2, -1);

        // Back-to-back bytes, including ones landing in the write cycle
        fill_random(5);
        run_load("back_to_back", 8'd5, 0, 0, -1);

        // Reset mid-load
        clear_obs();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        send_byte(8'd2, 1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("midreset writes", 64'(got_q.size()), 64'd0);
        chk("midreset done", 64'(done_cnt), 64'd0);
        chk("midreset addr", 64'(bus.o_inst_mem_addr), 64'd0);
        chk("midreset data", 64'(bus.o_inst_mem_data), 64'd0);

        stim_b.delete();
        stim_b.push_back(8'hDE);
        stim_b.push_back(8'hAD);
        stim_b.push_back(8'hBE);
        stim_b.push_back(8'hEF);
        run_load("after_reset", 8'd1, 0, 2, -1);
        if (got_q.size() > 0) begin
            tmp_w = got_q[0][IB-1:0];
            chk("deadbeef word", 64'(tmp_w), 64'(beef_w));
        end

        // Stray i_start during RECV
        fill_random(4);
        run_load("stray_start", 8'd4, 0, 2, 6);

        // Random loads
        for (int t = 0; t < 6; t++) begin
            n_rand = int'($urandom_range(12, 1));
            fill_random(n_rand);
            run_load("random", UB'(n_rand), 0, 3, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
